// File: rtl/sort4_seq_pkg.sv
// Shared types and constants for the sequential 4-element sorter.
// The pair schedule lists the five compare-exchange steps in execution order.
package sort4_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NSTEPS = 5;

  localparam logic [1:0] PAIR_I [NSTEPS] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd1};
  localparam logic [1:0] PAIR_J [NSTEPS] = '{2'd2, 2'd3, 2'd1, 2'd3, 2'd2};

endpackage

// File: rtl/sort4_seq_cmp_xchg.sv
// Single compare-exchange cell: orders two unsigned operands.
// Equal operands are passed through unswapped.
module cmp_xchg #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         swapped
);

  assign swapped = x > y;
  assign lo      = swapped ? y : x;
  assign hi      = swapped ? x : y;

endmodule

// File: rtl/sort4_seq.sv
// Sequential 4-input sorter sharing one compare-exchange cell over five steps.
// Define SORT4_SEQ_SWAPCNT_EN to add the swap_cnt output.
module sort4_seq
  import sort4_seq_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_c,
  input  logic [W-1:0] in_d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic [W-1:0] out_c,
  output logic [W-1:0] out_d,
  output logic         busy
`ifdef SORT4_SEQ_SWAPCNT_EN
  ,
  output logic [2:0]   swap_cnt
`endif
);

  state_t       r_state;
  state_t       w_nextState;
  logic [2:0]   r_step;
  logic [W-1:0] r_elem [4];

  logic         w_accept;
  logic         w_stepValid;
  logic         w_lastStep;
  logic [1:0]   w_idxI;
  logic [1:0]   w_idxJ;
  logic [W-1:0] w_x;
  logic [W-1:0] w_y;
  logic [W-1:0] w_lo;
  logic [W-1:0] w_hi;
  logic         w_swapped;

  assign w_accept    = in_valid && (r_state == IDLE);
  assign w_stepValid = r_step < 3'(NSTEPS);
  assign w_lastStep  = r_step == 3'(NSTEPS - 1);
  assign w_idxI      = w_stepValid ? PAIR_I[r_step] : 2'd0;
  assign w_idxJ      = w_stepValid ? PAIR_J[r_step] : 2'd0;
  assign w_x         = r_elem[w_idxI];
  assign w_y         = r_elem[w_idxJ];

  cmp_xchg #(.W(W)) u_cmpXchg (
    .x       (w_x),
    .y       (w_y),
    .lo      (w_lo),
    .hi      (w_hi),
    .swapped (w_swapped)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // An out-of-range step is treated as corruption and abandons the set.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_accept) w_nextState = CMP;
      CMP: begin
        if (w_lastStep)        w_nextState = DONE;
        else if (!w_stepValid) w_nextState = IDLE;
      end
      DONE: if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    busy      = (r_state == CMP);
    out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step <= 3'd0;
      for (int k = 0; k < 4; k++) r_elem[k] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_elem[0] <= in_a;
            r_elem[1] <= in_b;
            r_elem[2] <= in_c;
            r_elem[3] <= in_d;
            r_step    <= 3'd0;
          end
        end
        CMP: begin
          if (w_stepValid) begin
            r_elem[w_idxI] <= w_lo;
            r_elem[w_idxJ] <= w_hi;
          end
          r_step <= (w_stepValid && !w_lastStep) ? r_step + 3'd1 : 3'd0;
        end
        default: ;
      endcase
    end
  end

  assign out_a = r_elem[0];
  assign out_b = r_elem[1];
  assign out_c = r_elem[2];
  assign out_d = r_elem[3];

`ifdef SORT4_SEQ_SWAPCNT_EN
  logic [2:0] r_swapCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                             r_swapCnt <= 3'd0;
    else if (w_accept)                                   r_swapCnt <= 3'd0;
    else if (r_state == CMP && w_stepValid && w_swapped) r_swapCnt <= r_swapCnt + 3'd1;
  end

  assign swap_cnt = r_swapCnt;
`endif

endmodule

// File: tb/tb_sort4_seq.sv
// Scoreboard bench for sort4_seq: accepted sets are sorted by a reference model
// and queued; a negedge monitor checks results, latency and handshake behaviour.
module tb_sort4_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b, in_c, in_d;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_a, out_b, out_c, out_d;
  logic         busy;
`ifdef SORT4_SEQ_SWAPCNT_EN
  logic [2:0]   swap_cnt;
`endif

  sort4_seq #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_d      (in_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .busy      (busy)
`ifdef SORT4_SEQ_SWAPCNT_EN
    ,
    .swap_cnt  (swap_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][W-1:0] v;
    int                swaps;
    int                acceptCycle;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   checks      = 0;
  int   errors      = 0;
  int   cycle       = 0;
  int   lastAccept  = -1;
  bit   b2bMode     = 1'b0;
  bit   prevOutValid = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Sorted order by plain selection sort; swap count by walking the fixed network.
  function automatic exp_t refModel(input logic [W-1:0] a, b, c, d);
    exp_t e;
    int v[4];
    int n[4];
    int pi[5] = '{0, 1, 0, 2, 1};
    int pj[5] = '{2, 3, 1, 3, 2};
    int t;
    v[0] = int'(a); v[1] = int'(b); v[2] = int'(c); v[3] = int'(d);
    n = v;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (v[j] < v[i]) begin t = v[i]; v[i] = v[j]; v[j] = t; end
    for (int i = 0; i < 4; i++) e.v[i] = W'(v[i]);
    e.swaps = 0;
    for (int k = 0; k < 5; k++)
      if (n[pi[k]] > n[pj[k]]) begin
        t = n[pi[k]]; n[pi[k]] = n[pj[k]]; n[pj[k]] = t;
        e.swaps++;
      end
    e.acceptCycle = 0;
    return e;
  endfunction

  // Monitor: output checks first, then record any accept happening on the next edge.
  always @(negedge clk) begin
    if (rst) begin
      prevOutValid = 1'b0;
    end else begin
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedOutValid: got out_valid=1, expected 0 (cycle %0d)", cycle);
        end else begin
          monE = expQ[0];
          if (!prevOutValid) checkOutput("latency", cycle - monE.acceptCycle, 5);
          checkOutput("out_a", int'(out_a), int'(monE.v[0]));
          checkOutput("out_b", int'(out_b), int'(monE.v[1]));
          checkOutput("out_c", int'(out_c), int'(monE.v[2]));
          checkOutput("out_d", int'(out_d), int'(monE.v[3]));
`ifdef SORT4_SEQ_SWAPCNT_EN
          checkOutput("swap_cnt", int'(swap_cnt), monE.swaps);
`endif
          checkOutput("inReadyInDone", int'(in_ready), 0);
          checkOutput("busyInDone", int'(busy), 0);
          if (out_ready) void'(expQ.pop_front());
        end
      end else if (expQ.size() != 0) begin
        checkOutput("busyInCmp", int'(busy), 1);
        checkOutput("inReadyInCmp", int'(in_ready), 0);
      end
      prevOutValid = out_valid && !out_ready;
      if (in_valid && in_ready) begin
        monE = refModel(in_a, in_b, in_c, in_d);
        monE.acceptCycle = cycle + 1;
        if (b2bMode && lastAccept >= 0) checkOutput("acceptSpacing", monE.acceptCycle - lastAccept, 7);
        lastAccept = monE.acceptCycle;
        expQ.push_back(monE);
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, b, c, d, input bit hold);
    int n = 0;
    in_a = a; in_b = b; in_c = c; in_d = d;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL acceptTimeout: got in_ready=0, expected 1 within 100 cycles");
    end
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drainTimeout: got %0d outstanding, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_in_ready"}, int'(in_ready), 1);
    checkOutput({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_out_a", int'(out_a), 0);
    checkOutput("rst_out_d", int'(out_d), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkIdle("afterReset");

    applyStimulus(4'd9, 4'd7, 4'd3, 4'd1, 1'b0);
    waitDrain();
    applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    waitDrain();
    checkIdle("afterSorted");
    applyStimulus(4'd15, 4'd0, 4'd15, 4'd0, 1'b0);
    waitDrain();

    // Backpressure: result must stay put while the consumer stalls.
    out_ready = 1'b0;
    applyStimulus(4'd5, 4'd2, 4'd8, 4'd1, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("bpReached", int'(out_valid), 1);
    repeat (10) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkIdle("afterBackpressure");
    waitDrain();

    // Reset during the third compare step discards the partial set.
    applyStimulus(4'd6, 4'd9, 4'd1, 4'd4, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkIdle("afterMidReset");
    checkOutput("midReset_out_a", int'(out_a), 0);
    @(posedge clk); #1;
    checkOutput("midReset_noResidue", int'(out_valid), 0);
    applyStimulus(4'd4, 4'd3, 4'd2, 4'd1, 1'b0);
    waitDrain();

    // Back-to-back with in_valid held high.
    lastAccept = -1;
    b2bMode = 1'b1;
    for (int s = 0; s < 3; s++)
      applyStimulus(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                    W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), s != 2);
    waitDrain();
    b2bMode = 1'b0;

    for (int s = 0; s < 20; s++) begin
      applyStimulus(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0);
      waitDrain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 1000000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
